// File: rtl/alu_wb_stage.sv
// ALU writeback stage: 2-entry skid FIFO between the ALU and register-file writeback,
// plus the architectural N/Z/C/V flag register committed in order at retire.
module alu_wb_stage #(
    parameter int unsigned DW = 32,
    parameter int unsigned TW = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_res,
    input  logic          in_z,
    input  logic          in_c,
    input  logic          in_v,
    input  logic [2:0]    in_sel,
    input  logic [TW-1:0] in_tag,
    input  logic          in_setf,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_res,
    output logic [TW-1:0] out_tag,
    output logic          out_wen,
    output logic          flag_n,
    output logic          flag_z,
    output logic          flag_c,
    output logic          flag_v,
    output logic          err_sel,
    output logic [15:0]   retire_cnt
);

    localparam int unsigned CW = 16;

    // ok: sel is a real op; lgc: and/or/not, whose C/V commit as 0
    typedef struct packed {
        logic [DW-1:0] res;
        logic [TW-1:0] tag;
        logic          ok;
        logic          lgc;
        logic          setf;
        logic          z;
        logic          c;
        logic          v;
    } entry_t;

    typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} occ_t;

    occ_t   state, state_nx;
    entry_t head, skid, incoming;
    logic   accept, retire;
    logic   head_ld, skid_ld, shift;

    assign accept = in_valid & in_ready;
    assign retire = out_valid & out_ready;

    always_comb begin
        incoming.res  = in_res;
        incoming.tag  = in_tag;
        incoming.ok   = (in_sel <= 3'b100);
        incoming.lgc  = (in_sel == 3'b010) || (in_sel == 3'b011) || (in_sel == 3'b100);
        incoming.setf = in_setf;
        incoming.z    = in_z;
        incoming.c    = in_c;
        incoming.v    = in_v;
    end

    always_ff @(posedge clk) begin
        if (rst) state <= EMPTY;
        else     state <= state_nx;
    end

    // Occupancy transitions; on accept+retire the new entry replaces the retiring head
    always_comb begin
        state_nx = state;
        head_ld  = 1'b0;
        skid_ld  = 1'b0;
        shift    = 1'b0;
        case (state)
            EMPTY: begin
                if (accept) begin
                    head_ld  = 1'b1;
                    state_nx = ONE;
                end
            end
            ONE: begin
                if (accept && retire) begin
                    head_ld = 1'b1;
                end else if (accept) begin
                    skid_ld  = 1'b1;
                    state_nx = TWO;
                end else if (retire) begin
                    state_nx = EMPTY;
                end
            end
            TWO: begin
                if (retire) begin
                    shift    = 1'b1;
                    state_nx = ONE;
                end
            end
            default: state_nx = EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head       <= '0;
            skid       <= '0;
            in_ready   <= 1'b1;
            out_valid  <= 1'b0;
            flag_n     <= 1'b0;
            flag_z     <= 1'b0;
            flag_c     <= 1'b0;
            flag_v     <= 1'b0;
            err_sel    <= 1'b0;
            retire_cnt <= '0;
        end else begin
            in_ready  <= (state_nx != TWO);
            out_valid <= (state_nx != EMPTY);
            if (head_ld)    head <= incoming;
            else if (shift) head <= skid;
            if (skid_ld)    skid <= incoming;
            if (retire) begin
                retire_cnt <= retire_cnt + CW'(1);
                if (!head.ok) err_sel <= 1'b1;
                if (head.ok && head.setf) begin
                    flag_n <= head.res[DW-1];
                    flag_z <= head.z;
                    flag_c <= head.c & ~head.lgc;
                    flag_v <= head.v & ~head.lgc;
                end
            end
        end
    end

    assign out_res = head.res;
    assign out_tag = head.tag;
    assign out_wen = head.ok;

endmodule

// File: tb/tb_alu_wb_stage.sv
// Directed bench for alu_wb_stage: hand-computed vectors checked with immediate assertions.
module tb_alu_wb_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready;
    logic [31:0] in_res;
    logic        in_z, in_c, in_v;
    logic [2:0]  in_sel;
    logic [4:0]  in_tag;
    logic        in_setf;
    logic        out_valid, out_ready;
    logic [31:0] out_res;
    logic [4:0]  out_tag;
    logic        out_wen;
    logic        flag_n, flag_z, flag_c, flag_v;
    logic        err_sel;
    logic [15:0] retire_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    alu_wb_stage #(.DW(32), .TW(5)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_res(in_res), .in_z(in_z), .in_c(in_c), .in_v(in_v),
        .in_sel(in_sel), .in_tag(in_tag), .in_setf(in_setf),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_res(out_res), .out_tag(out_tag), .out_wen(out_wen),
        .flag_n(flag_n), .flag_z(flag_z), .flag_c(flag_c), .flag_v(flag_v),
        .err_sel(err_sel), .retire_cnt(retire_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [2:0] sel, input logic [31:0] res, input logic z,
                         input logic c, input logic v, input logic setf, input logic [4:0] tag);
        in_valid = 1'b1;
        in_sel   = sel;
        in_res   = res;
        in_z     = z;
        in_c     = c;
        in_v     = v;
        in_setf  = setf;
        in_tag   = tag;
    endtask

    task automatic check_flags(input string tag, input logic [3:0] nzcv);
        check(tag, 32'({flag_n, flag_z, flag_c, flag_v}), 32'(nzcv));
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        in_res = '0; in_z = 1'b0; in_c = 1'b0; in_v = 1'b0;
        in_sel = '0; in_tag = '0; in_setf = 1'b0;
        tick(); tick();
        rst = 1'b0;

        // Reset state
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_res", out_res, 32'd0);
        check("rst_out_tag", 32'(out_tag), 32'd0);
        check("rst_out_wen", 32'(out_wen), 32'd0);
        check_flags("rst_flags", 4'b0000);
        check("rst_err", 32'(err_sel), 32'd0);
        check("rst_cnt", 32'(retire_cnt), 32'd0);

        // Add overflow
        out_ready = 1'b1;
        drive(3'b000, 32'h8000_0000, 1'b0, 1'b0, 1'b1, 1'b1, 5'd3);
        tick();
        check("add_valid", 32'(out_valid), 32'd1);
        check("add_res", out_res, 32'h8000_0000);
        check("add_tag", 32'(out_tag), 32'd3);
        check("add_wen", 32'(out_wen), 32'd1);
        check_flags("add_flags_pre", 4'b0000);
        in_valid = 1'b0;
        tick();
        check_flags("add_flags", 4'b1001);
        check("add_empty", 32'(out_valid), 32'd0);
        check("add_cnt", 32'(retire_cnt), 32'd1);

        // Subtract to zero
        drive(3'b001, 32'd0, 1'b1, 1'b1, 1'b0, 1'b1, 5'd4);
        tick();
        in_valid = 1'b0;
        tick();
        check_flags("sub_flags", 4'b0110);

        // Logical op without commit: flags stay NZCV=0110
        drive(3'b010, 32'd0, 1'b1, 1'b0, 1'b1, 1'b0, 5'd5);
        tick();
        check("and_wen", 32'(out_wen), 32'd1);
        in_valid = 1'b0;
        tick();
        check_flags("and_flags_held", 4'b0110);

        // Logical op with commit: C and V forced to 0
        drive(3'b011, 32'h0000_0007, 1'b0, 1'b1, 1'b1, 1'b1, 5'd6);
        tick();
        in_valid = 1'b0;
        tick();
        check_flags("or_flags", 4'b0000);
        check("or_cnt", 32'(retire_cnt), 32'd4);

        // Backpressure: tags 1,2 buffered, tag 3 held upstream
        out_ready = 1'b0;
        drive(3'b000, 32'h11, 1'b0, 1'b0, 1'b0, 1'b0, 5'd1);
        tick();
        check("bp_ready1", 32'(in_ready), 32'd1);
        drive(3'b000, 32'h22, 1'b0, 1'b0, 1'b0, 1'b0, 5'd2);
        tick();
        check("bp_ready2", 32'(in_ready), 32'd0);
        check("bp_head_tag", 32'(out_tag), 32'd1);
        drive(3'b000, 32'h33, 1'b0, 1'b0, 1'b0, 1'b0, 5'd3);
        tick();
        check("bp_ready3", 32'(in_ready), 32'd0);
        check("bp_hold_tag", 32'(out_tag), 32'd1);
        check("bp_hold_res", out_res, 32'h11);
        check("bp_hold_cnt", 32'(retire_cnt), 32'd4);
        out_ready = 1'b1;
        tick();
        check("bp_tag2", 32'(out_tag), 32'd2);
        check("bp_res2", out_res, 32'h22);
        tick();
        check("bp_tag3", 32'(out_tag), 32'd3);
        check("bp_res3", out_res, 32'h33);
        in_valid = 1'b0;
        tick();
        check("bp_drained", 32'(out_valid), 32'd0);
        check("bp_cnt", 32'(retire_cnt), 32'd7);
        check_flags("bp_flags", 4'b0000);

        // Sustained throughput with out_ready held
        drive(3'b001, 32'h44, 1'b0, 1'b0, 1'b0, 1'b0, 5'd4);
        tick();
        check("tp_tag4", 32'(out_tag), 32'd4);
        in_tag = 5'd5;
        tick();
        check("tp_tag5", 32'(out_tag), 32'd5);
        check("tp_ready", 32'(in_ready), 32'd1);
        in_tag = 5'd6;
        tick();
        check("tp_tag6", 32'(out_tag), 32'd6);
        in_valid = 1'b0;
        tick();
        check("tp_cnt", 32'(retire_cnt), 32'd10);

        // Invalid sel
        drive(3'b110, 32'h1234, 1'b1, 1'b1, 1'b1, 1'b1, 5'd9);
        tick();
        check("inv_valid", 32'(out_valid), 32'd1);
        check("inv_wen", 32'(out_wen), 32'd0);
        check("inv_err_pre", 32'(err_sel), 32'd0);
        in_valid = 1'b0;
        tick();
        check_flags("inv_flags", 4'b0000);
        check("inv_err", 32'(err_sel), 32'd1);
        tick();
        check("inv_err_sticky", 32'(err_sel), 32'd1);
        check("inv_cnt", 32'(retire_cnt), 32'd11);

        // Reset mid-operation with two committing entries buffered
        out_ready = 1'b0;
        drive(3'b000, 32'h8000_0000, 1'b1, 1'b1, 1'b1, 1'b1, 5'd7);
        tick();
        in_tag = 5'd8;
        tick();
        check("mr_full", 32'(in_ready), 32'd0);
        in_valid = 1'b0;
        out_ready = 1'b1;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mr_valid", 32'(out_valid), 32'd0);
        check("mr_ready", 32'(in_ready), 32'd1);
        check_flags("mr_flags", 4'b0000);
        check("mr_cnt", 32'(retire_cnt), 32'd0);
        check("mr_err", 32'(err_sel), 32'd0);
        tick();
        check("mr_valid_after", 32'(out_valid), 32'd0);
        check_flags("mr_flags_after", 4'b0000);
        check("mr_cnt_after", 32'(retire_cnt), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_wb_stage.md
Name: alu_wb_stage

Overview:
- Registered stage directly downstream of the 32-bit ALU. It captures the ALU's combinational result (res, z, c, v) together with the op select and destination tag.
- It buffers the result in a 2-entry skid buffer with a valid/ready handshake, and presents it to register-file writeback.
- It also maintains the architectural condition-flag register (N, Z, C, V). Flags commit in program order when a result leaves the stage.

Parameters:
- DW, 32, result data width; must match the ALU operand width.
- TW, 5, destination register tag width.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous active-high reset.
- in_valid  in  1  upstream (ALU) result valid.
- in_ready  out  1  stage can accept a result this cycle.
- in_res  in  DW  ALU result.
- in_z  in  1  ALU zero flag.
- in_c  in  1  ALU carry flag.
- in_v  in  1  ALU overflow flag.
- in_sel  in  3  op select the ALU used: 000 add, 001 sub, 010 and, 011 or, 100 not; 101-111 invalid.
- in_tag  in  TW  destination register index.
- in_setf  in  1  commit flags for this op.
- out_valid  out  1  result available to writeback.
- out_ready  in  1  writeback accepts the result.
- out_res  out  DW  buffered result.
- out_tag  out  TW  buffered destination.
- out_wen  out  1  register write enable; 0 when the entry's sel is invalid.
- flag_n  out  1  architectural N flag.
- flag_z  out  1  architectural Z flag.
- flag_c  out  1  architectural C flag.
- flag_v  out  1  architectural V flag.
- err_sel  out  1  sticky: an invalid-sel entry has been retired.
- retire_cnt  out  16  count of retired entries (valid and invalid).

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high (rst), sampled on the rising edge of clk.
- Reset values:
  - Buffer empty; out_valid=0, in_ready=1.
  - out_res=0, out_tag=0, out_wen=0.
  - All flags 0, err_sel=0, retire_cnt=0.
- Reset mid-operation: buffered entries are discarded and no flag update occurs that cycle.
- Handshake:
  - Input accepted on in_valid&in_ready.
  - Output retired on out_valid&out_ready.
  - in_valid and payload must stay stable while in_ready=0; the upstream is responsible for this.
- Buffer: 2-entry FIFO (main register plus skid register).
  - in_ready=1 when occupancy is below 2. in_ready is registered and does not depend combinationally on out_ready.
  - out_valid=1 when occupancy is at least 1. out_* always reflects the oldest entry.
- Latency: an accepted input is visible at out_* one cycle later when the buffer was empty. Sustained throughput is 1 per cycle with out_ready held 1.
- Occupancy states:
  - EMPTY → ONE on accept.
  - ONE → ONE on accept+retire.
  - ONE → TWO on accept with no retire.
  - ONE → EMPTY on retire with no accept.
  - TWO → ONE on retire. No accept is possible in TWO.
- Ordering on simultaneous accept and retire: the retire takes the oldest entry and the new entry is appended. Order is strictly FIFO.
- Entry stores res, tag, sel-valid bit (sel ≤ 100), setf, z, c, v. N is captured as res[DW-1].
- Flag commit happens on the retire cycle, only when setf=1 and sel is valid:
  - N=res[DW-1]; Z=stored z; C=stored c; V=stored v.
  - For and/or/not, C and V are written as 0.
  - Flags are otherwise held.
- Invalid sel:
  - out_wen=0 while the entry is at the head.
  - Flags are not updated.
  - err_sel is set on retire and stays set until rst.
- retire_cnt increments by 1 per retire and wraps from 0xFFFF to 0.
- Backpressure with out_ready=0: out_* and flags are held stable; at most 2 entries are buffered, then in_ready=0.

Test Plan:
- Add overflow:
  - Stimulus: reset, then in_sel=000, in_res=0x80000000, c=0, v=1, setf=1, tag=3, out_ready=1.
  - Required: next cycle out_valid=1, out_res=0x80000000, out_tag=3, out_wen=1; after retire N=1, Z=0, C=0, V=1.
- Subtract to zero:
  - Stimulus: in_sel=001, res=0, z=1, c=1, setf=1.
  - Required: after retire Z=1, C=1, N=0, V=0.
- Logical op without flag commit:
  - Stimulus: in_sel=010, res=0, z=1, setf=0.
  - Required: out_wen=1; flags unchanged from the prior values.
- Backpressure:
  - Stimulus: hold out_ready=0 and push 3 entries with tags 1, 2, 3.
  - Required:
    - in_ready=0 after 2 accepts.
    - Tag 3 is held upstream.
    - Releasing out_ready yields tags 1, 2, 3 in order over 3 consecutive cycles.
    - retire_cnt=3.
- Invalid sel:
  - Stimulus: in_sel=110, res=0x1234, setf=1.
  - Required: out_valid=1, out_wen=0; flags unchanged; err_sel=1 after retire and held until rst.
- Reset mid-operation:
  - Stimulus: 2 entries buffered, assert rst for 1 cycle.
  - Required: out_valid=0, in_ready=1, flags=0, retire_cnt=0, err_sel=0; no commit from the discarded entries.
